// File: rtl/lab1_imul_int_mul_var_pkg.sv
// lab1_imul_pkg: shared op and FSM state encodings for the iterative multiplier
package lab1_imul_pkg;
  typedef enum logic [1:0] {MUL, MULH, MULHSU, MULHU} op_e;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
endpackage

// File: rtl/lab1_imul_int_mul_var_if.sv
// lab1_imul_int_mul_var_if: val/rdy request {op,a,b} and response (product half) channels
interface lab1_imul_int_mul_var_if #(parameter int NBITS = 32);
  logic                 req_val;
  logic                 req_rdy;
  logic [2*NBITS+1:0]   req_msg;
  logic                 resp_val;
  logic                 resp_rdy;
  logic [NBITS-1:0]     resp_msg;
  modport master (output req_val, req_msg, resp_rdy, input req_rdy, resp_val, resp_msg);
  modport slave (input req_val, req_msg, resp_rdy, output req_rdy, resp_val, resp_msg);
endinterface

// File: rtl/lab1_imul_int_mul_var_dpath.sv
// lab1_imul_int_mul_var_dpath: shift-add datapath; load/calc from control, b_last flags final step
// ports: clk, reset (async active-low), load, calc, req_msg in; b_last, resp_msg out
module lab1_imul_int_mul_var_dpath
  import lab1_imul_pkg::*;
#(parameter int NBITS = 32) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               calc,
  input  logic [2*NBITS+1:0] req_msg,
  output logic               b_last,
  output logic [NBITS-1:0]   resp_msg
);
  logic [2*NBITS-1:0] a_reg, result, sres;
  logic [NBITS-1:0]   b_reg, a_in, b_in, a_abs, b_abs;
  logic               neg, hi, a_neg, b_neg;
  op_e                op;
  assign op    = op_e'(req_msg[2*NBITS+1 -: 2]);
  assign a_in  = req_msg[2*NBITS-1 -: NBITS];
  assign b_in  = req_msg[NBITS-1:0];
  // only operands treated as signed by the op get their magnitude taken
  assign a_neg = a_in[NBITS-1] && (op == MULH || op == MULHSU);
  assign b_neg = b_in[NBITS-1] && op == MULH;
  assign a_abs = a_neg ? -a_in : a_in;
  assign b_abs = b_neg ? -b_in : b_in;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      a_reg  <= '0;
      b_reg  <= '0;
      result <= '0;
      neg    <= 1'b0;
      hi     <= 1'b0;
    end else if (load) begin
      a_reg  <= {{NBITS{1'b0}}, a_abs};
      b_reg  <= b_abs;
      result <= '0;
      neg    <= a_neg ^ b_neg;
      hi     <= op != MUL;
    end else if (calc) begin
      if (b_reg[0]) result <= result + a_reg;
      a_reg <= a_reg << 1;
      b_reg <= b_reg >> 1;
    end
  // early exit: no set bits remain above the one consumed this cycle
  assign b_last   = ~|b_reg[NBITS-1:1];
  assign sres     = neg ? -result : result;
  assign resp_msg = hi ? sres[2*NBITS-1:NBITS] : sres[NBITS-1:0];
endmodule

// File: rtl/lab1_imul_int_mul_var.sv
// lab1_imul_int_mul_var: variable-latency shift-add multiplier (MUL/MULH/MULHSU/MULHU) with control FSM
// ports: clk, reset (async active-low), ifc (slave: req val/rdy/msg, resp val/rdy/msg)
module lab1_imul_int_mul_var
  import lab1_imul_pkg::*;
#(parameter int NBITS = 32) (
  input logic                     clk,
  input logic                     reset,
  lab1_imul_int_mul_var_if.slave  ifc
);
  state_e state, state_n;
  logic   b_last;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (ifc.req_val ? CALC : IDLE)
            : state == CALC ? (b_last ? DONE : CALC)
            : (ifc.resp_rdy ? IDLE : DONE);
  end
  assign ifc.req_rdy  = state == IDLE;
  assign ifc.resp_val = state == DONE;
  lab1_imul_int_mul_var_dpath #(.NBITS(NBITS)) dp (
    .clk      (clk),
    .reset    (reset),
    .load     (ifc.req_val && state == IDLE),
    .calc     (state == CALC),
    .req_msg  (ifc.req_msg),
    .b_last   (b_last),
    .resp_msg (ifc.resp_msg)
  );
endmodule

// File: tb/tb_lab1_imul_int_mul_var.sv
// tb_lab1_imul_int_mul_var: directed self-checking bench with per-cycle line trace
module tb_lab1_imul_int_mul_var;
  import lab1_imul_pkg::*;
  localparam int N = 32;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  lab1_imul_int_mul_var_if #(.NBITS(N)) ifc ();
  lab1_imul_int_mul_var #(.NBITS(N)) dut (.clk(clk), .reset(reset), .ifc(ifc));
  function automatic string st_str();
    if (dut.state == CALC) return dut.dp.b_reg[0] ? "C+" : "C ";
    return dut.state == DONE ? "D " : "I ";
  endfunction
  always @(negedge clk)
    $display("%t %b:%h | %h %h %s | %b:%h", $time, ifc.req_val && ifc.req_rdy, ifc.req_msg,
             dut.dp.a_reg, dut.dp.b_reg, st_str(), ifc.resp_val && ifc.resp_rdy, ifc.resp_msg);
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int k, input int hold);
    int n = 0;
    int w = 0;
    while (!ifc.req_rdy && w < 50) begin tick(); w++; end
    check({tag, " req_rdy"}, 64'(ifc.req_rdy), 64'd1);
    ifc.req_val = 1'b1;
    ifc.req_msg = {op, a, b};
    tick();
    ifc.req_val = 1'b0;
    ifc.req_msg = '1;
    check({tag, " busy"}, 64'(ifc.req_rdy), 64'd0);
    while (!ifc.resp_val && n < 100) begin tick(); n++; end
    check({tag, " latency"}, 64'(n), 64'(k));
    check({tag, " msg"}, 64'(ifc.resp_msg), 64'(exp));
    for (int i = 0; i < hold; i++) begin
      ifc.req_val = 1'b1;
      ifc.req_msg = {2'd0, 32'd9, 32'd9};
      tick();
      check({tag, " hold msg"}, 64'(ifc.resp_msg), 64'(exp));
      check({tag, " hold val"}, 64'(ifc.resp_val), 64'd1);
      check({tag, " hold rdy"}, 64'(ifc.req_rdy), 64'd0);
    end
    ifc.req_val = 1'b0;
    ifc.resp_rdy = 1'b1;
    tick();
    ifc.resp_rdy = 1'b0;
    check({tag, " post rdy"}, 64'(ifc.req_rdy), 64'd1);
    check({tag, " post val"}, 64'(ifc.resp_val), 64'd0);
  endtask
  initial begin
    int seen = 0;
    ifc.req_val  = 1'b0;
    ifc.req_msg  = '0;
    ifc.resp_rdy = 1'b0;
    #12;
    check("reset req_rdy", 64'(ifc.req_rdy), 64'd1);
    check("reset resp_val", 64'(ifc.resp_val), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    do_op("mul 3x4", MUL, 32'd3, 32'd4, 32'h0000000C, 3, 0);
    do_op("mul 7x0", MUL, 32'd7, 32'd0, 32'h00000000, 1, 0);
    do_op("mulhu ff", MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32, 0);
    do_op("mul ff", MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32, 5);
    do_op("mulh min", MULH, 32'h80000000, 32'h80000000, 32'h40000000, 32, 0);
    do_op("mulhsu ff", MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32, 0);
    do_op("mulh -3x5", MULH, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 3, 0);
    do_op("mul -3x5", MUL, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 3, 0);
    do_op("mulhsu 2xff", MULHSU, 32'd2, 32'hFFFFFFFF, 32'h00000001, 32, 0);
    ifc.req_val = 1'b1;
    ifc.req_msg = {MUL, 32'd5, 32'hFFFFFFFF};
    tick();
    ifc.req_val = 1'b0;
    repeat (5) tick();
    #3 reset = 1'b0;
    #1;
    check("midcalc rst resp_val", 64'(ifc.resp_val), 64'd0);
    check("midcalc rst req_rdy", 64'(ifc.req_rdy), 64'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (40) begin
      if (ifc.resp_val) seen++;
      tick();
    end
    check("no resp after rst", 64'(seen), 64'd0);
    do_op("mul 6x7", MUL, 32'd6, 32'd7, 32'h0000002A, 3, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lab1_imul_int_mul_var.md
LAB1_IMUL_INT_MUL_VAR -- requirements
Module: lab1_imul_int_mul_var

Interface
REQ-001: Parameter NBITS, default 32, operand and result width; legal values 8..64.
REQ-002: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003: reset  input  1  asynchronous, active-low reset.
REQ-004: req_val  input  1  request valid.
REQ-005: req_rdy  output  1  request ready.
REQ-006: req_msg  input  2*NBITS+2  {op[1:0], a[NBITS-1:0], b[NBITS-1:0]}, op at MSBs, b at LSBs.
REQ-007: resp_val  output  1  response valid.
REQ-008: resp_rdy  input  1  response ready.
REQ-009: resp_msg  output  NBITS  selected product half.

Function
REQ-010: op encoding SHALL be: 0 MUL (low half), 1 MULH (signed x signed, high), 2 MULHSU (signed a x unsigned b, high), 3 MULHU (unsigned x unsigned, high).
REQ-011: FSM states SHALL be IDLE, CALC, DONE; IDLE->CALC on req_val && req_rdy; CALC->DONE on last step; DONE->IDLE on resp_val && resp_rdy; otherwise hold.
REQ-012: req_rdy SHALL be 1 only in IDLE; resp_val SHALL be 1 only in DONE; no request/response overlap.
REQ-013: On accept, registers SHALL load: a_reg (2*NBITS) = zero-extended |a|, b_reg (NBITS) = |b|, result (2*NBITS) = 0, neg = sign(a) XOR sign(b), hi = (op != MUL); |x| applies only to operands signed under op.
REQ-014: Each CALC cycle: if b_reg[0] then result += a_reg (mod 2^(2*NBITS)); a_reg <<= 1; b_reg >>= 1.
REQ-015: CALC SHALL exit (early termination) in the cycle where (b_reg >> 1) == 0; CALC cycle count = max(1, msb_index(|b|)+1), range 1..NBITS; no separate counter.
REQ-016: Latency: request accepted in cycle t -> resp_val high in cycle t+1+k, k = CALC cycle count.
REQ-017: resp_msg SHALL equal bits [NBITS-1:0] (hi=0) or [2*NBITS-1:NBITS] (hi=1) of (neg ? -result : result), two's complement over 2*NBITS bits, combinational from registered state.
REQ-018: Most-negative signed operand (-2^(NBITS-1)) SHALL be handled exactly; magnitude fits in NBITS unsigned.
REQ-019: In DONE with resp_rdy=0, resp_msg and resp_val SHALL stay stable indefinitely.
REQ-020: req_msg SHALL be ignored outside the IDLE accept cycle; a new request is accepted no earlier than the cycle after the response handshake.
REQ-021: In IDLE, resp_msg value is don't-care; resp_val SHALL be 0.

Reset
REQ-022: reset low SHALL immediately force state IDLE, req_rdy 1, resp_val 0, clear a_reg, b_reg, result, neg, hi, independent of clk.
REQ-023: Reset during CALC or DONE SHALL abandon the transaction; no response is ever produced for it.
REQ-024: First accept possible on the first rising edge after reset deasserts.

Structure
REQ-025: Package lab1_imul_pkg SHALL hold the op enum (MUL, MULH, MULHSU, MULHU) and the state enum (IDLE, CALC, DONE).
REQ-026: Datapath (operand muxes, abs/negate, shifters, adder, registers, output select) SHALL be sub-module lab1_imul_int_mul_var_dpath; control FSM in the top module.
REQ-027: Line trace SHALL show request, a_reg, b_reg, state (I/C/D, with "+" on add steps), response.

Verification (NBITS=32)
REQ-028: MUL a=3, b=4 -> k=3, resp_msg 0x0000000C at t+4.
REQ-029: MUL a=7, b=0 -> k=1, resp_msg 0x00000000 at t+2.
REQ-030: MULHU a=b=0xFFFFFFFF -> k=32, resp_msg 0xFFFFFFFE; same operands with MUL -> 0x00000001.
REQ-031: MULH a=b=0x80000000 -> 0x40000000; MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
REQ-032: resp_rdy held 0 for 5 cycles in DONE -> resp_msg, resp_val stable, req_rdy 0 throughout; handshake -> req_rdy 1 next cycle.
REQ-033: reset pulsed low mid-CALC -> resp_val 0 and req_rdy 1 immediately; subsequent MUL 6x7 returns 0x0000002A.
